// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ stage controller: instruction codes,
// processor status codes and the stage state encoding.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } stage_t;

endpackage

// File: rtl/mem_access_decode.sv
// Classifies an instruction code: does it read or write data memory, and is
// it a defined Y86-64 instruction at all. Purely combinational.
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       mem_read,
    output logic       mem_write,
    output logic       icode_valid
);

    // Table lookup of memory direction and validity per instruction code
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        icode_valid = 1'b1;
        case (icode)
            ICODE_RMMOVQ, ICODE_CALL, ICODE_PUSHQ: mem_write = 1'b1;
            ICODE_MRMOVQ, ICODE_RET,  ICODE_POPQ:  mem_read  = 1'b1;
            ICODE_HALT, ICODE_NOP, ICODE_RRMOVQ,
            ICODE_IRMOVQ, ICODE_OPQ, ICODE_JXX:    ;
            default:                               icode_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks one instruction
// through FETCH..PCUPD, strobes one stage enable per cycle, handshakes data
// memory with a bounded wait, tracks status and counts retires and cycles.
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
)
(
    input  logic             clk,
    input  logic             async_reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_update_en,
    output logic             cc_set,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // Last MEMORY cycle index (0-based) in which mem_ready is still accepted
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    stage_t            state_reg, state_next;
    logic [3:0]        icode_reg;
    logic [2:0]        stat_reg, stat_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]  retired_reg, cycle_reg;
    logic              retire;

    logic [3:0] dec_icode;
    logic       dec_read, dec_write, dec_valid;
    logic       mem_access;

    // In FETCH the live icode is being validated; afterwards the latched one drives memory direction
    assign dec_icode  = (state_reg == ST_FETCH) ? icode : icode_reg;
    assign mem_access = dec_read | dec_write;

    mem_access_decode u_decode (
        .icode       (dec_icode),
        .mem_read    (dec_read),
        .mem_write   (dec_write),
        .icode_valid (dec_valid)
    );

    // Stage state register
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next stage, status update, memory wait count and retire decision
    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        wait_next  = wait_reg;
        retire     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Instruction-memory fault outranks an undefined icode
                if (imem_error) begin
                    state_next = ST_HALT;
                    stat_next  = STAT_ADR;
                end else if (!dec_valid) begin
                    state_next = ST_HALT;
                    stat_next  = STAT_INS;
                end else if (icode == ICODE_HALT) begin
                    state_next = ST_HALT;
                    stat_next  = STAT_HLT;
                    retire     = 1'b1;
                end else begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE:  state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = ST_MEMORY;
            ST_MEMORY: begin
                if (!mem_access) begin
                    state_next = ST_WRITEBACK;
                end else if (dmem_error) begin
                    state_next = ST_HALT;
                    stat_next  = STAT_ADR;
                    wait_next  = '0;
                end else if (mem_ready) begin
                    state_next = ST_WRITEBACK;
                    wait_next  = '0;
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = ST_HALT;
                    stat_next  = STAT_ADR;
                    wait_next  = '0;
                end else begin
                    wait_next  = wait_reg + WAIT_W'(1);
                end
            end
            ST_WRITEBACK: state_next = ST_PCUPD;
            ST_PCUPD: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latched icode, status, memory wait counter and the two free-running counters
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            icode_reg   <= ICODE_HALT;
            stat_reg    <= STAT_AOK;
            wait_reg    <= '0;
            retired_reg <= '0;
            cycle_reg   <= '0;
        end else begin
            if (state_reg == ST_FETCH) icode_reg <= icode;
            stat_reg <= stat_next;
            wait_reg <= wait_next;
            if (retire) retired_reg <= retired_reg + CNT_W'(1);
            if (state_reg != ST_IDLE && state_reg != ST_HALT) cycle_reg <= cycle_reg + CNT_W'(1);
        end
    end

    // Stage strobes and memory requests decoded from the current stage
    always_comb begin
        fetch_en     = (state_reg == ST_FETCH);
        decode_en    = (state_reg == ST_DECODE);
        execute_en   = (state_reg == ST_EXECUTE);
        memory_en    = (state_reg == ST_MEMORY);
        writeback_en = (state_reg == ST_WRITEBACK);
        pc_update_en = (state_reg == ST_PCUPD);
        halted       = (state_reg == ST_HALT);
        cc_set       = (state_reg == ST_EXECUTE) && (icode_reg == ICODE_OPQ);
        mem_read     = (state_reg == ST_MEMORY) && dec_read;
        mem_write    = (state_reg == ST_MEMORY) && dec_write;
    end

    assign stat          = stat_reg;
    assign retired_count = retired_reg;
    assign cycle_count   = cycle_reg;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: each scenario pushes its
// hand-derived per-cycle observations before driving stimulus; a negedge
// monitor pops and compares whenever a stage strobe fires or HALT is entered.
module tb_seq_stage_controller;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             async_reset = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       icode = 4'h0;
    logic             imem_error = 1'b0;
    logic             dmem_error = 1'b0;
    logic             mem_ready = 1'b0;
    logic             fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en;
    logic             cc_set, mem_read, mem_write, halted;
    logic [2:0]       stat;
    logic [CNT_W-1:0] retired_count, cycle_count;

    seq_stage_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk           (clk),
        .async_reset   (async_reset),
        .start         (start),
        .icode         (icode),
        .imem_error    (imem_error),
        .dmem_error    (dmem_error),
        .mem_ready     (mem_ready),
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .execute_en    (execute_en),
        .memory_en     (memory_en),
        .writeback_en  (writeback_en),
        .pc_update_en  (pc_update_en),
        .cc_set        (cc_set),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .stat          (stat),
        .halted        (halted),
        .retired_count (retired_count),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  strobes;  // {F,D,E,M,W,P}
        logic        cc;
        logic        rd;
        logic        wr;
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] ret;
        logic [31:0] cyc;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          evt_no = 0;
    logic [31:0] exp_ret = 0;
    logic [31:0] exp_cyc = 0;
    bit          halted_prev = 1'b0;

    // Monitor: one line per observed transaction, compared against the queue head
    always @(negedge clk) begin
        obs_t act;
        obs_t expo;
        if (!async_reset) begin
            halted_prev = 1'b0;
        end else begin
            act.strobes = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en};
            act.cc      = cc_set;
            act.rd      = mem_read;
            act.wr      = mem_write;
            act.stat    = stat;
            act.halted  = halted;
            act.ret     = retired_count;
            act.cyc     = cycle_count;
            if ((|act.strobes) || (halted && !halted_prev)) begin
                checks++;
                evt_no++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ev%0d unexpected: strb=%b stat=%0d halt=%b ret=%0d cyc=%0d",
                             evt_no, act.strobes, act.stat, act.halted, act.ret, act.cyc);
                end else begin
                    expo = exp_q.pop_front();
                    if (act !== expo) begin
                        failures++;
                        $display("FAIL ev%0d got strb=%b cc=%b rd=%b wr=%b stat=%0d halt=%b ret=%0d cyc=%0d expected strb=%b cc=%b rd=%b wr=%b stat=%0d halt=%b ret=%0d cyc=%0d",
                                 evt_no, act.strobes, act.cc, act.rd, act.wr, act.stat, act.halted, act.ret, act.cyc,
                                 expo.strobes, expo.cc, expo.rd, expo.wr, expo.stat, expo.halted, expo.ret, expo.cyc);
                    end else begin
                        $display("ev%0d ok strb=%b cc=%b rd=%b wr=%b stat=%0d halt=%b ret=%0d cyc=%0d",
                                 evt_no, act.strobes, act.cc, act.rd, act.wr, act.stat, act.halted, act.ret, act.cyc);
                    end
                end
            end
            halted_prev = halted;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end else begin
            $display("%s ok value=%0h", nm, got);
        end
    endtask

    task automatic push_obs(input logic [5:0] s, input logic cc, input logic rd, input logic wr);
        obs_t o;
        o.strobes = s;  o.cc = cc;  o.rd = rd;  o.wr = wr;
        o.stat = 3'd1;  o.halted = 1'b0;
        o.ret = exp_ret; o.cyc = exp_cyc;
        exp_q.push_back(o);
        exp_cyc = exp_cyc + 1;
    endtask

    task automatic push_halt(input logic [2:0] st);
        obs_t o;
        o.strobes = 6'b0; o.cc = 1'b0; o.rd = 1'b0; o.wr = 1'b0;
        o.stat = st; o.halted = 1'b1;
        o.ret = exp_ret; o.cyc = exp_cyc;
        exp_q.push_back(o);
    endtask

    // Full instruction: F, D, E, k x M, W, P; retires on leaving P
    task automatic exp_instr(input logic cc, input logic rd, input logic wr, input int k);
        push_obs(6'b100000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b010000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b001000, cc,   1'b0, 1'b0);
        for (int i = 0; i < k; i++) push_obs(6'b000100, 1'b0, rd, wr);
        push_obs(6'b000010, 1'b0, 1'b0, 1'b0);
        push_obs(6'b000001, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 1;
    endtask

    task automatic exp_fetch_halt(input logic [2:0] st, input bit retire);
        push_obs(6'b100000, 1'b0, 1'b0, 1'b0);
        if (retire) exp_ret = exp_ret + 1;
        push_halt(st);
    endtask

    task automatic exp_mem_fault(input logic rd, input logic wr, input int k);
        push_obs(6'b100000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b010000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b001000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < k; i++) push_obs(6'b000100, 1'b0, rd, wr);
        push_halt(3'd3);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_strobes"}, {54'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en,
                               pc_update_en, cc_set, mem_read, mem_write, halted}, 64'd0);
        chk({nm, "_stat"}, {61'd0, stat}, 64'd1);
        chk({nm, "_counts"}, {retired_count, cycle_count}, 64'd0);
    endtask

    task automatic drain(input string nm);
        chk({nm, "_drain"}, exp_q.size(), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        async_reset = 1'b0;
        start = 1'b0; icode = 4'h0; imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
        #1;
        check_idle_outputs(nm);
        tick();
        tick();
        async_reset = 1'b1;
        exp_q.delete();
        exp_ret = 0;
        exp_cyc = 0;
    endtask

    // Issue start, then step to the first FETCH cycle
    task automatic kick(input logic [3:0] ic);
        icode = ic;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2;
        do_reset("reset0");

        // irmovq then halt
        exp_instr(1'b0, 1'b0, 1'b0, 1);
        exp_fetch_halt(3'd2, 1'b1);
        kick(4'h3);
        repeat (6) tick();
        icode = 4'h0;
        repeat (3) tick();
        chk("irmovq_retired", retired_count, 64'd2);
        drain("irmovq");

        // OPq: cc_set only in the execute cycle
        do_reset("reset1");
        exp_instr(1'b1, 1'b0, 1'b0, 1);
        exp_fetch_halt(3'd2, 1'b1);
        kick(4'h6);
        repeat (6) tick();
        icode = 4'h0;
        repeat (3) tick();
        drain("opq");

        // mrmovq with mem_ready in the 4th MEMORY cycle
        do_reset("reset2");
        exp_instr(1'b0, 1'b1, 1'b0, 4);
        exp_fetch_halt(3'd2, 1'b1);
        kick(4'h5);
        repeat (3) tick();
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("mrmovq_cycles", cycle_count, 64'd9);
        icode = 4'h0;
        repeat (3) tick();
        drain("mrmovq");

        // rmmovq: dmem_error beats mem_ready in the first MEMORY cycle
        do_reset("reset3");
        exp_mem_fault(1'b0, 1'b1, 1);
        kick(4'h4);
        repeat (3) tick();
        dmem_error = 1'b1;
        mem_ready  = 1'b1;
        tick();
        dmem_error = 1'b0;
        mem_ready  = 1'b0;
        tick();
        chk("rmmovq_retired", retired_count, 64'd0);
        drain("rmmovq");

        // undefined icode 0xC
        do_reset("reset4");
        exp_fetch_halt(3'd4, 1'b0);
        kick(4'hC);
        repeat (2) tick();
        drain("ins");

        // imem_error outranks undefined icode
        do_reset("reset5");
        exp_fetch_halt(3'd3, 1'b0);
        imem_error = 1'b1;
        kick(4'hC);
        tick();
        imem_error = 1'b0;
        tick();
        drain("imem");

        // halt instruction, then start is ignored
        do_reset("reset6");
        exp_fetch_halt(3'd2, 1'b1);
        kick(4'h0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("halt_sticky", {halted, stat}, {1'b1, 3'd2});
        chk("halt_counts", {retired_count, cycle_count}, {32'd1, 32'd1});
        drain("halt");

        // pushq: no mem_ready for MEM_TIMEOUT cycles
        do_reset("reset7");
        exp_mem_fault(1'b0, 1'b1, MEM_TIMEOUT);
        kick(4'hA);
        repeat (3) tick();
        repeat (MEM_TIMEOUT) tick();
        tick();
        chk("timeout_stat", stat, 64'd3);
        drain("timeout");

        // popq: mem_ready in the last allowed MEMORY cycle is still accepted
        do_reset("reset8");
        exp_instr(1'b0, 1'b1, 1'b0, MEM_TIMEOUT);
        exp_fetch_halt(3'd2, 1'b1);
        kick(4'hB);
        repeat (3) tick();
        repeat (MEM_TIMEOUT - 1) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        icode = 4'h0;
        repeat (3) tick();
        drain("lastready");

        // reset asserted mid-EXECUTE clears everything at once
        do_reset("reset9");
        push_obs(6'b100000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b010000, 1'b0, 1'b0, 1'b0);
        push_obs(6'b001000, 1'b0, 1'b0, 1'b0);
        kick(4'h3);
        repeat (2) tick();
        #5;
        async_reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        drain("midreset");
        tick();
        async_reset = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
